// File: rtl/imem_fetch_pkg.sv
// Shared constants and width helpers for the instruction-memory fetch stage FIFO.
package imem_fetch_pkg;

    localparam int DEFAULT_WORD_W         = 48;
    localparam int DEFAULT_WORDS_PER_BANK = 5;
    localparam int DEFAULT_NUM_BANKS      = 2;
    localparam int DEFAULT_DEPTH          = 4;

    function automatic int bundle_width(input int num_banks, input int words_per_bank, input int word_w);
        return num_banks * words_per_bank * word_w;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry array still needs a one-bit index.
    function automatic int index_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/imem_fetch_store.sv
// Circular register array holding the bundles queued behind the output register.
module imem_fetch_store
    import imem_fetch_pkg::*;
#(
    parameter int DATA_W  = 480,
    parameter int ENTRIES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              write,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    output logic [DATA_W-1:0] read_data,
    output logic              empty
);

    localparam int PTR_W  = index_width(ENTRIES);
    localparam int FILL_W = count_width(ENTRIES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES - 1);

    logic [DATA_W-1:0] slots [ENTRIES];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;

    // Entry count need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty     = (fill == '0);
    assign read_data = slots[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (write)
                wr_ptr <= advance(wr_ptr);
            if (read)
                rd_ptr <= advance(rd_ptr);
            if (write && !read)
                fill <= fill + FILL_W'(1);
            else if (read && !write)
                fill <= fill - FILL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (write)
            slots[wr_ptr] <= write_data;
    end

endmodule

// File: rtl/imem_fetch_stage_fifo.sv
// Fetch-bundle FIFO between instruction SRAM banks and decode: output register
// plus a DEPTH-1 entry store, with per-bank masking, flush and occupancy.
module imem_fetch_stage_fifo
    import imem_fetch_pkg::*;
#(
    parameter  int WORD_W         = DEFAULT_WORD_W,
    parameter  int WORDS_PER_BANK = DEFAULT_WORDS_PER_BANK,
    parameter  int NUM_BANKS      = DEFAULT_NUM_BANKS,
    parameter  int DEPTH          = DEFAULT_DEPTH,
    localparam int DATA_W         = bundle_width(NUM_BANKS, WORDS_PER_BANK, WORD_W),
    localparam int COUNT_W        = count_width(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [NUM_BANKS-1:0] bank_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    input  logic                 flush,
    output logic [COUNT_W-1:0]   count,
    output logic                 drop_seen
);

    localparam int BANK_W = WORDS_PER_BANK * WORD_W;
    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

    logic [DATA_W-1:0] masked_data;
    logic [DATA_W-1:0] store_data;
    logic              store_empty;
    logic              push;
    logic              pop;
    logic              load_out;
    logic              bypass;
    logic              store_write;
    logic              store_read;

    always_comb begin
        masked_data = in_data;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!bank_en[b])
                masked_data[b*BANK_W +: BANK_W] = '0;
        end
    end

    // No pass-through when full: in_ready looks only at the registered count.
    assign in_ready    = (count < FULL) && !flush;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready && !flush;
    assign load_out    = !out_valid || pop;
    assign store_read  = load_out && !store_empty && !flush;
    assign bypass      = push && load_out && store_empty;
    assign store_write = push && !bypass;

    imem_fetch_store #(
        .DATA_W  (DATA_W),
        .ENTRIES (DEPTH - 1)
    ) store (
        .clock      (clock),
        .reset      (reset),
        .clear      (flush),
        .write      (store_write),
        .write_data (masked_data),
        .read       (store_read),
        .read_data  (store_data),
        .empty      (store_empty)
    );

    // Flush keeps out_data so decode never sees a spurious bundle change.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            count     <= '0;
            drop_seen <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            count     <= '0;
            if (in_valid)
                drop_seen <= 1'b1;
        end else begin
            if (load_out) begin
                if (!store_empty) begin
                    out_valid <= 1'b1;
                    out_data  <= store_data;
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_data  <= masked_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (push && !pop)
                count <= count + COUNT_W'(1);
            else if (pop && !push)
                count <= count - COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imem_fetch_stage_fifo.sv
// Scoreboard bench for imem_fetch_stage_fifo: default configuration directed
// sequences, then a 4x2x32 depth-8 instance under random stalls.
module tb_imem_fetch_stage_fifo;

    localparam int W0 = 48, WPB0 = 5, NB0 = 2, D0 = 4, DW0 = 480, CW0 = 3;
    localparam int W1 = 32, WPB1 = 2, NB1 = 4, D1 = 8, DW1 = 256, CW1 = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic           in_valid0, in_ready0, out_valid0, out_ready0, flush0, drop_seen0;
    logic [DW0-1:0] in_data0, out_data0;
    logic [NB0-1:0] bank_en0;
    logic [CW0-1:0] count0;

    logic           in_valid1, in_ready1, out_valid1, out_ready1, flush1, drop_seen1;
    logic [DW1-1:0] in_data1, out_data1;
    logic [NB1-1:0] bank_en1;
    logic [CW1-1:0] count1;

    imem_fetch_stage_fifo dut0 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .bank_en   (bank_en0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .flush     (flush0),
        .count     (count0),
        .drop_seen (drop_seen0)
    );

    imem_fetch_stage_fifo #(
        .WORD_W         (W1),
        .WORDS_PER_BANK (WPB1),
        .NUM_BANKS      (NB1),
        .DEPTH          (D1)
    ) dut1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .bank_en   (bank_en1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .flush     (flush1),
        .count     (count1),
        .drop_seen (drop_seen1)
    );

    int errors = 0;
    int checks = 0;

    logic [DW0-1:0] sb0[$];
    logic [DW0-1:0] last0;
    int             model_count0;
    logic           model_drop0;

    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DW0-1:0] mkBundle0(input int base);
        logic [DW0-1:0] r;
        r = '0;
        for (int k = 0; k < NB0*WPB0; k++)
            r[k*W0 +: W0] = W0'(base + k);
        return r;
    endfunction

    function automatic logic [DW0-1:0] mask0(input logic [DW0-1:0] d, input logic [NB0-1:0] en);
        logic [DW0-1:0] r;
        r = d;
        for (int b = 0; b < NB0; b++)
            if (!en[b]) r[b*WPB0*W0 +: WPB0*W0] = '0;
        return r;
    endfunction

    task automatic resetDut();
        reset = 1'b1;
        in_valid0 = 0; in_data0 = '0; bank_en0 = '1; out_ready0 = 0; flush0 = 0;
        in_valid1 = 0; in_data1 = '0; bank_en1 = '1; out_ready1 = 0; flush1 = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb0.delete();
        last0 = '0;
        model_count0 = 0;
        model_drop0 = 1'b0;
    endtask

    // One cycle on dut0: drive, check registered state against the model, clock.
    task automatic applyStimulus(input logic iv, input logic [DW0-1:0] data, input logic [NB0-1:0] ben,
                                 input logic ordy, input logic fl);
        logic do_push, do_pop;
        in_valid0 = iv; in_data0 = data; bank_en0 = ben; out_ready0 = ordy; flush0 = fl;
        #1;
        checkOutput("out_valid", out_valid0, sb0.size() > 0);
        checkOutput("out_data", out_data0, last0);
        checkOutput("count", count0, model_count0);
        checkOutput("in_ready", in_ready0, (model_count0 < D0) && !fl);
        checkOutput("drop_seen", drop_seen0, model_drop0);
        do_push = iv && (model_count0 < D0) && !fl;
        do_pop  = (sb0.size() > 0) && ordy && !fl;
        if (fl) begin
            sb0.delete();
            model_count0 = 0;
            if (iv) model_drop0 = 1'b1;
        end else begin
            if (do_pop) void'(sb0.pop_front());
            if (do_push) sb0.push_back(mask0(data, ben));
            model_count0 = model_count0 + int'(do_push) - int'(do_pop);
            if (sb0.size() > 0) last0 = sb0[0];
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [DW0-1:0] ref_bundle;
        logic [DW1-1:0] sb1[$];
        logic [DW1-1:0] rnd;
        logic           iv, ordy;
        int             model_count1, sent, received, cyc;

        @(negedge clock);
        resetDut();
        repeat (3) applyStimulus(0, '0, '1, 0, 0);

        // Fill to capacity with the output stalled, then hold.
        for (int i = 0; i < 4; i++) applyStimulus(1, mkBundle0(1 + 10*i), '1, 0, 0);
        repeat (2) applyStimulus(0, '0, '1, 0, 0);
        // Full: a pop this cycle must not admit the offered bundle.
        applyStimulus(1, mkBundle0(41), '1, 1, 0);
        applyStimulus(1, mkBundle0(41), '1, 0, 0);
        repeat (6) applyStimulus(0, '0, '1, 1, 0);

        applyStimulus(1, mkBundle0(1), 2'b10, 0, 0);
        ref_bundle = mkBundle0(1);
        checkOutput("mask_bank0_zero", out_data0[WPB0*W0-1:0], '0);
        checkOutput("mask_bank1_kept", out_data0[DW0-1:WPB0*W0], ref_bundle[DW0-1:WPB0*W0]);
        applyStimulus(0, '0, '1, 1, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, mkBundle0(100 + 10*i), '1, 0, 0);
        applyStimulus(1, mkBundle0(200), '1, 1, 1);
        checkOutput("flush_count", count0, 0);
        checkOutput("flush_out_valid", out_valid0, 0);
        checkOutput("flush_drop_seen", drop_seen0, 1);
        applyStimulus(1, mkBundle0(300), '1, 0, 0);
        checkOutput("post_flush_valid", out_valid0, 1);
        applyStimulus(1, mkBundle0(310), '1, 0, 0);

        resetDut();
        applyStimulus(0, '0, '1, 0, 0);
        applyStimulus(0, '0, '1, 1, 0);

        // Wider, deeper instance under random stalls.
        model_count1 = 0; sent = 0; received = 0; cyc = 0;
        while (received < 100 && cyc < 3000) begin
            iv   = (sent < 100) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < DW1/32; k++) rnd[k*32 +: 32] = $urandom;
            in_valid1 = iv; in_data1 = rnd; out_ready1 = ordy;
            #1;
            checkOutput("rand_count", count1, model_count1);
            checkOutput("rand_count_le8", count1 <= CW1'(D1), 1);
            checkOutput("rand_out_valid", out_valid1, sb1.size() > 0);
            if (out_valid1 && ordy && sb1.size() > 0) begin
                checkOutput("rand_data", out_data1, sb1.pop_front());
                received++;
                model_count1--;
            end
            if (iv && model_count1 + int'(ordy && out_valid1) <= D1 && (model_count1 + int'(ordy && out_valid1)) < D1 + 1
                && ((model_count1 + int'(ordy && out_valid1)) < D1)) begin
                sb1.push_back(rnd);
                sent++;
                model_count1++;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        in_valid1 = 0; out_ready1 = 0;
        checkOutput("rand_received", received, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
